// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl
//   Sequencing controller for the E-stage multiply/divide unit. It accepts MDU
//   ops from E and runs the multi-cycle latency counter for mult/div. It tells
//   the datapath when to capture operands (cap_en) and when to commit
//   temp_HI/LO into HI/LO (commit). It also raises the D-stage stall for any
//   instruction that touches HI/LO or the MDU.
// Ports
//   clk, reset     rising-edge clock, async active-low reset
//   e_start/e_op   E-stage MDU op: 1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo
//   e_cancel       flush of the E-stage op and of any in-flight op
//   d_mdu_use      D-stage instruction is an MDU/HI/LO op
//   cap_en         operand capture strobe (combinational)
//   run_op         opcode of the in-flight op, 0 when idle (registered)
//   commit         HI/LO commit strobe on the last busy cycle (combinational)
//   hi_we, lo_we   mthi/mtlo write enables (combinational)
//   busy           an op is in flight (registered)
//   stall          D-stage stall request (combinational)
//   done_cnt       wrapping count of committed mult/div ops (registered)
module mdu_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_start,
  input  logic [3:0]  e_op,
  input  logic        e_cancel,
  input  logic        d_mdu_use,
  output logic        cap_en,
  output logic [3:0]  run_op,
  output logic        commit,
  output logic        hi_we,
  output logic        lo_we,
  output logic        busy,
  output logic        stall,
  output logic [15:0] done_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_md;
  logic             is_mul;
  logic             accept;

  assign is_mul = (e_op == OP_MULT) || (e_op == OP_MULTU);
  assign is_md  = is_mul || (e_op == OP_DIV) || (e_op == OP_DIVU);

  assign busy   = (state == RUN);
  // Starts while busy are stall-protocol violations; gating on IDLE / ~busy
  // simply drops them without disturbing the in-flight op.
  assign accept = e_start & is_md & ~e_cancel & (state == IDLE);
  assign cap_en = accept;
  // A cancel on the final count cycle wins, so the commit is suppressed too.
  assign commit = busy & (cnt == CNT_ONE) & ~e_cancel;
  assign hi_we  = e_start & (e_op == OP_MTHI) & ~e_cancel & ~busy;
  assign lo_we  = e_start & (e_op == OP_MTLO) & ~e_cancel & ~busy;
  // The commit cycle still stalls; D issues once busy drops and sees new HI/LO.
  assign stall  = d_mdu_use & (busy | accept);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      run_op   <= '0;
      done_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= RUN;
            run_op <= e_op;
            cnt    <= is_mul ? MULT_LOAD : DIV_LOAD;
          end
        end
        RUN: begin
          if (e_cancel) begin
            state  <= IDLE;
            cnt    <= '0;
            run_op <= '0;
          end else if (cnt == CNT_ONE) begin
            state    <= IDLE;
            cnt      <= '0;
            run_op   <= '0;
            done_cnt <= done_cnt + 16'd1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          run_op <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
module tb_mdu_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        e_start, e_cancel, d_mdu_use;
  logic [3:0]  e_op;
  logic        cap_en, commit, hi_we, lo_we, busy, stall;
  logic [3:0]  run_op;
  logic [15:0] done_cnt;

  int total = 0;
  int bad   = 0;

  mdu_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .e_start(e_start), .e_op(e_op),
    .e_cancel(e_cancel), .d_mdu_use(d_mdu_use), .cap_en(cap_en),
    .run_op(run_op), .commit(commit), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .stall(stall), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    e_start = 0; e_op = 4'd0; e_cancel = 0; d_mdu_use = 0;
  endtask

  task automatic test_reset;
    idle_in();
    reset = 0;
    d_mdu_use = 1;
    #3;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (run_op !== 4'd0) begin bad++; $display("FAIL rst_run_op got=%0d exp=0", run_op); end
    total++; if (done_cnt !== 16'd0) begin bad++; $display("FAIL rst_done_cnt got=%0d exp=0", done_cnt); end
    total++; if ({cap_en, commit, hi_we, lo_we, stall} !== 5'b0) begin bad++;
      $display("FAIL rst_comb got=%b exp=00000", {cap_en, commit, hi_we, lo_we, stall}); end
    tick(); tick();
    reset = 1;
    idle_in();
    tick();
  endtask

  // mult accepted at edge 0: busy cycles 1..5, commit only in cycle 5.
  task automatic test_mult;
    logic eb, ec;
    e_start = 1; e_op = 4'd1; #1;
    total++; if (cap_en !== 1'b1) begin bad++; $display("FAIL mult_cap got=%b exp=1", cap_en); end
    tick();
    idle_in();
    for (int k = 1; k <= 6; k++) begin
      #1;
      eb = (k <= 5); ec = (k == 5);
      total++; if (busy !== eb) begin bad++; $display("FAIL mult_busy c%0d got=%b exp=%b", k, busy, eb); end
      total++; if (commit !== ec) begin bad++; $display("FAIL mult_commit c%0d got=%b exp=%b", k, commit, ec); end
      if (k == 1) begin
        total++; if (run_op !== 4'd1) begin bad++; $display("FAIL mult_run_op got=%0d exp=1", run_op); end
      end
      if (k == 6) begin
        total++; if (done_cnt !== 16'd1) begin bad++; $display("FAIL mult_done got=%0d exp=1", done_cnt); end
        total++; if (run_op !== 4'd0) begin bad++; $display("FAIL mult_run_op_idle got=%0d exp=0", run_op); end
      end
      tick();
    end
  endtask

  // divu with D stalled throughout: stall for accept cycle plus 10 busy cycles.
  task automatic test_divu_stall;
    logic es, ec;
    d_mdu_use = 1; e_start = 1; e_op = 4'd4; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL divu_stall_acc got=%b exp=1", stall); end
    tick();
    e_start = 0; e_op = 4'd0;
    for (int k = 1; k <= 11; k++) begin
      #1;
      es = (k <= 10); ec = (k == 10);
      total++; if (stall !== es) begin bad++; $display("FAIL divu_stall c%0d got=%b exp=%b", k, stall, es); end
      total++; if (commit !== ec) begin bad++; $display("FAIL divu_commit c%0d got=%b exp=%b", k, commit, ec); end
      tick();
    end
    idle_in();
    total++; if (done_cnt !== 16'd2) begin bad++; $display("FAIL divu_done got=%0d exp=2", done_cnt); end
  endtask

  task automatic test_cancel;
    int ncommit;
    // div cancelled in busy cycle 3
    e_start = 1; e_op = 4'd3; tick(); idle_in();
    tick(); tick();
    e_cancel = 1; #1;
    total++; if (commit !== 1'b0) begin bad++; $display("FAIL cancel_commit got=%b exp=0", commit); end
    tick(); e_cancel = 0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b exp=0", busy); end
    total++; if (run_op !== 4'd0) begin bad++; $display("FAIL cancel_run_op got=%0d exp=0", run_op); end
    ncommit = 0;
    for (int k = 0; k < 12; k++) begin
      if (commit) ncommit++;
      tick();
    end
    total++; if (ncommit != 0) begin bad++; $display("FAIL cancel_no_commit got=%0d exp=0", ncommit); end
    total++; if (done_cnt !== 16'd2) begin bad++; $display("FAIL cancel_done got=%0d exp=2", done_cnt); end
    // cancel on the final count cycle beats the commit
    e_start = 1; e_op = 4'd2; tick(); idle_in();
    tick(); tick(); tick(); tick();
    e_cancel = 1; #1;
    total++; if (commit !== 1'b0) begin bad++; $display("FAIL cancel_last_commit got=%b exp=0", commit); end
    tick(); e_cancel = 0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_last_busy got=%b exp=0", busy); end
    total++; if (done_cnt !== 16'd2) begin bad++; $display("FAIL cancel_last_done got=%0d exp=2", done_cnt); end
    // cancel together with start: nothing accepted, no write enables
    e_start = 1; e_cancel = 1; e_op = 4'd1; #1;
    total++; if (cap_en !== 1'b0) begin bad++; $display("FAIL cancel_start_cap got=%b exp=0", cap_en); end
    e_op = 4'd5; #1;
    total++; if (hi_we !== 1'b0) begin bad++; $display("FAIL cancel_start_hi got=%b exp=0", hi_we); end
    e_op = 4'd6; #1;
    total++; if (lo_we !== 1'b0) begin bad++; $display("FAIL cancel_start_lo got=%b exp=0", lo_we); end
    tick(); idle_in(); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_start_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mthi;
    e_start = 1; e_op = 4'd5; #1;
    total++; if ({hi_we, lo_we} !== 2'b10) begin bad++; $display("FAIL mthi_idle got=%b exp=10", {hi_we, lo_we}); end
    tick(); idle_in(); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b exp=0", busy); end
    total++; if (hi_we !== 1'b0) begin bad++; $display("FAIL mthi_pulse got=%b exp=0", hi_we); end
    e_start = 1; e_op = 4'd6; #1;
    total++; if ({hi_we, lo_we} !== 2'b01) begin bad++; $display("FAIL mtlo_idle got=%b exp=01", {hi_we, lo_we}); end
    tick();
    // mthi and an illegal div while a mult is in flight
    e_op = 4'd1; tick(); // mult accepted, now busy cycle 1
    e_op = 4'd5; #1;
    total++; if (hi_we !== 1'b0) begin bad++; $display("FAIL mthi_while_busy got=%b exp=0", hi_we); end
    tick();
    e_op = 4'd3; #1;
    total++; if (cap_en !== 1'b0) begin bad++; $display("FAIL div_while_busy got=%b exp=0", cap_en); end
    tick(); idle_in(); #1;
    total++; if (run_op !== 4'd1) begin bad++; $display("FAIL busy_run_op got=%0d exp=1", run_op); end
    tick(); tick(); #1; // cycle 5
    total++; if (commit !== 1'b1) begin bad++; $display("FAIL busy_mult_commit got=%b exp=1", commit); end
    tick();
    total++; if (done_cnt !== 16'd3) begin bad++; $display("FAIL busy_mult_done got=%0d exp=3", done_cnt); end
  endtask

  task automatic test_reset_mid;
    e_start = 1; e_op = 4'd1; tick(); idle_in();
    tick(); // cycle 2
    #2;
    reset = 0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (run_op !== 4'd0) begin bad++; $display("FAIL rmid_run_op got=%0d exp=0", run_op); end
    total++; if (dut.cnt !== 4'd0) begin bad++; $display("FAIL rmid_cnt got=%0d exp=0", dut.cnt); end
    total++; if (done_cnt !== 16'd0) begin bad++; $display("FAIL rmid_done got=%0d exp=0", done_cnt); end
    total++; if (commit !== 1'b0) begin bad++; $display("FAIL rmid_commit got=%b exp=0", commit); end
    tick();
    reset = 1;
    tick();
  endtask

  // mult at edge 0, commit cycle 5; div issued in cycle 6, commit cycle 16.
  task automatic test_back_to_back;
    logic eb, ec;
    e_start = 1; e_op = 4'd1; tick(); idle_in();
    for (int k = 1; k <= 17; k++) begin
      if (k == 6) begin e_start = 1; e_op = 4'd3; end
      #1;
      eb = (k <= 5) || (k >= 7 && k <= 16);
      ec = (k == 5) || (k == 16);
      if (k == 6) begin
        total++; if (cap_en !== 1'b1) begin bad++; $display("FAIL b2b_cap got=%b exp=1", cap_en); end
      end
      total++; if (busy !== eb) begin bad++; $display("FAIL b2b_busy c%0d got=%b exp=%b", k, busy, eb); end
      total++; if (commit !== ec) begin bad++; $display("FAIL b2b_commit c%0d got=%b exp=%b", k, commit, ec); end
      tick();
      idle_in();
    end
    total++; if (done_cnt !== 16'd2) begin bad++; $display("FAIL b2b_done got=%0d exp=2", done_cnt); end
  endtask

  task automatic test_wrap;
    force dut.done_cnt = 16'hFFFF;
    #1;
    release dut.done_cnt;
    #1;
    total++; if (done_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preset got=%h exp=ffff", done_cnt); end
    e_start = 1; e_op = 4'd2; tick(); idle_in();
    for (int k = 1; k <= 5; k++) tick();
    total++; if (done_cnt !== 16'h0000) begin bad++; $display("FAIL wrap got=%h exp=0000", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_stall();
    test_cancel();
    test_mthi();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
